// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared constants and FSM encoding for the PWM fade controller
`timescale 1ns/1ps
package pwm_fade_pkg;

   localparam logic [9:0] REG_CTRL     = 10'h000;
   localparam logic [9:0] REG_PRESCALE = 10'h004;
   localparam logic [9:0] REG_MAX      = 10'h008;
   localparam logic [9:0] REG_CH_MASK  = 10'h00C;
   localparam logic [9:0] REG_STATUS   = 10'h010;

   localparam int unsigned STATUS_DIR_BIT  = 16;
   localparam int unsigned STATUS_BUSY_BIT = 17;
   localparam int unsigned STATUS_OVR_BIT  = 18;

   // Downstream PWM wrapper layout: one 8-byte window per channel
   localparam int unsigned PW_OFFSET  = 0;
   localparam int unsigned CTR_OFFSET = 4;
   localparam int unsigned CH_STRIDE  = 8;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      UPDATE
   } fade_state_e;

endpackage

// File: rtl/pwm_fade_prescaler.sv
// rtl/pwm_fade_prescaler.sv - reloadable down-counter producing the fade step tick
`timescale 1ns/1ps
module pwm_fade_prescaler #(
   parameter int unsigned PrescaleWidth = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic [PrescaleWidth-1:0] prescale_i,
   output logic                     tick_o
);

   logic [PrescaleWidth-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == '0);

   // While disabled the counter tracks PRESCALE so the first tick lands PRESCALE+1 cycles after enable
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (!en_i || (cnt_q == '0)) begin
         cnt_q <= prescale_i;
      end else begin
         cnt_q <= cnt_q - PrescaleWidth'(1);
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - breathing-fade bus master rewriting PWM channel pulse widths
`timescale 1ns/1ps
module pwm_fade_ctrl
   import pwm_fade_pkg::*;
#(
   parameter int unsigned NumChannels   = 12,
   parameter int unsigned CtrSize       = 8,
   parameter int unsigned BusWidth      = 32,
   parameter int unsigned PrescaleWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                device_req_i,
   input  logic [BusWidth-1:0] device_addr_i,
   input  logic                device_we_i,
   input  logic [3:0]          device_be_i,
   input  logic [BusWidth-1:0] device_wdata_i,
   output logic                device_rvalid_o,
   output logic [BusWidth-1:0] device_rdata_o,
   output logic                pwm_req_o,
   input  logic                pwm_gnt_i,
   output logic [BusWidth-1:0] pwm_addr_o,
   output logic                pwm_we_o,
   output logic [3:0]          pwm_be_o,
   output logic [BusWidth-1:0] pwm_wdata_o
);

   localparam int unsigned ChIdxW = $clog2(NumChannels + 1);

   logic                     en_q;
   logic [PrescaleWidth-1:0] prescale_q;
   logic [CtrSize-1:0]       max_q;
   logic [NumChannels-1:0]   mask_q;
   logic [CtrSize-1:0]       level_q, level_d;
   logic                     dir_q, dir_d;
   logic                     pending_q, pending_d;
   logic                     overrun_q;
   fade_state_e              state_q, state_d;
   logic [ChIdxW-1:0]        ch_idx_q, ch_idx_d;
   logic                     req_q, req_d;
   logic [9:0]               addr_q, addr_d;
   logic [CtrSize-1:0]       data_q, data_d;
   logic                     rvalid_q;
   logic [BusWidth-1:0]      rdata_q, rdata_d;

   logic [9:0]        bus_off;
   logic              bus_wr, ctrl_wr, en_d, en_rise;
   logic              tick, tick_eff, busy, accept, slot_free;
   logic              ovr_set, ovr_clr;
   logic              found;
   logic [ChIdxW-1:0] found_idx;
   logic              unused_bits;

   assign bus_off     = device_addr_i[9:0];
   assign bus_wr      = device_req_i && device_we_i;
   assign ctrl_wr     = bus_wr && (bus_off == REG_CTRL);
   assign en_d        = ctrl_wr ? device_wdata_i[0] : en_q;
   assign en_rise     = ctrl_wr && device_wdata_i[0] && !en_q;
   assign unused_bits = ^{device_be_i, device_addr_i, device_wdata_i};

   pwm_fade_prescaler #(
      .PrescaleWidth(PrescaleWidth)
   ) u_prescaler (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_q),
      .prescale_i(prescale_q),
      .tick_o    (tick)
   );

   // A CTRL write in the tick cycle decides whether that tick counts
   assign tick_eff  = tick && en_d;
   assign busy      = (state_q != IDLE);
   assign accept    = !busy && en_d && (tick_eff || pending_q);
   assign slot_free = !req_q || pwm_gnt_i;
   assign ovr_set   = busy && tick_eff && pending_q;
   assign ovr_clr   = bus_wr && (bus_off == REG_STATUS) && device_wdata_i[STATUS_OVR_BIT];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q       <= 1'b0;
         prescale_q <= '0;
         max_q      <= '0;
         mask_q     <= '0;
      end else if (bus_wr) begin
         case (bus_off)
            REG_CTRL:     en_q       <= device_wdata_i[0];
            REG_PRESCALE: prescale_q <= PrescaleWidth'(device_wdata_i);
            REG_MAX:      max_q      <= CtrSize'(device_wdata_i);
            REG_CH_MASK:  mask_q     <= NumChannels'(device_wdata_i);
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata_d = '0;
      case (bus_off)
         REG_CTRL:     rdata_d[0]                 = en_q;
         REG_PRESCALE: rdata_d[PrescaleWidth-1:0] = prescale_q;
         REG_MAX:      rdata_d[CtrSize-1:0]       = max_q;
         REG_CH_MASK:  rdata_d                    = BusWidth'(mask_q);
         REG_STATUS: begin
            rdata_d[CtrSize-1:0]    = level_q;
            rdata_d[STATUS_DIR_BIT]  = dir_q;
            rdata_d[STATUS_BUSY_BIT] = busy;
            rdata_d[STATUS_OVR_BIT]  = overrun_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= device_req_i;
         rdata_q  <= (device_req_i && !device_we_i) ? rdata_d : '0;
      end
   end

   // Lowest enabled channel at or above ch_idx_q; skipped channels cost no cycles
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      for (int i = NumChannels - 1; i >= 0; i--) begin
         if (mask_q[i] && (ChIdxW'(i) >= ch_idx_q)) begin
            found     = 1'b1;
            found_idx = ChIdxW'(i);
         end
      end
   end

   always_comb begin
      level_d = level_q;
      dir_d   = dir_q;
      if (accept) begin
         if (level_q > max_q) begin
            level_d = max_q;
            dir_d   = 1'b1;
         end else if (!dir_q) begin
            if (level_q == max_q) begin
               dir_d   = 1'b1;
               level_d = (max_q == '0) ? '0 : level_q - CtrSize'(1);
            end else begin
               level_d = level_q + CtrSize'(1);
            end
         end else if (level_q == '0) begin
            dir_d   = 1'b0;
            level_d = (max_q == '0) ? '0 : CtrSize'(1);
         end else begin
            level_d = level_q - CtrSize'(1);
         end
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (!en_d) begin
         pending_d = 1'b0;
      end else if (!busy) begin
         if (tick_eff || pending_q) pending_d = tick_eff && pending_q;
      end else if (tick_eff) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      ch_idx_d = ch_idx_q;
      req_d    = req_q;
      addr_d   = addr_q;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            req_d    = 1'b0;
            ch_idx_d = '0;
            if (en_rise) begin
               state_d = INIT;
            end else if (accept) begin
               state_d = UPDATE;
            end
         end
         default: begin
            // A stalled beat holds its address and data until granted, even when EN drops
            if (slot_free) begin
               if (!en_d || !found) begin
                  state_d = IDLE;
                  req_d   = 1'b0;
               end else begin
                  req_d    = 1'b1;
                  addr_d   = 10'(32'(found_idx) * CH_STRIDE +
                                 ((state_q == INIT) ? CTR_OFFSET : PW_OFFSET));
                  data_d   = (state_q == INIT) ? max_q : level_q;
                  ch_idx_d = found_idx + ChIdxW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ch_idx_q  <= '0;
         req_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         level_q   <= '0;
         dir_q     <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_idx_q  <= ch_idx_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         level_q   <= level_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         overrun_q <= ovr_set || (overrun_q && !ovr_clr);
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;
   assign pwm_req_o       = req_q;
   assign pwm_addr_o      = BusWidth'(addr_q);
   assign pwm_wdata_o     = BusWidth'(data_q);
   assign pwm_we_o        = 1'b1;
   assign pwm_be_o        = 4'hF;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - randomized self-checking bench for pwm_fade_ctrl
`timescale 1ns/1ps
module tb_pwm_fade_ctrl;

   localparam logic [9:0] A_CTRL = 10'h000, A_PRESC = 10'h004, A_MAX = 10'h008;
   localparam logic [9:0] A_MASK = 10'h00C, A_STAT  = 10'h010;

   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        device_req_i = 1'b0, device_we_i = 1'b0;
   logic [31:0] device_addr_i = '0, device_wdata_i = '0;
   logic [3:0]  device_be_i = 4'hF;
   logic        device_rvalid_o;
   logic [31:0] device_rdata_o;
   logic        pwm_req_o, pwm_gnt_i = 1'b1, pwm_we_o;
   logic [31:0] pwm_addr_o, pwm_wdata_o;
   logic [3:0]  pwm_be_o;

   int checks = 0, failures = 0, cyc = 0;
   bit gnt_hold = 0, gnt_rand = 0;
   logic [31:0] q_addr[$], q_data[$];
   int          q_cyc[$];
   bit          prev_stall = 0;
   logic [31:0] prev_a, prev_d;

   pwm_fade_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .device_req_i(device_req_i), .device_addr_i(device_addr_i), .device_we_i(device_we_i),
      .device_be_i(device_be_i), .device_wdata_i(device_wdata_i),
      .device_rvalid_o(device_rvalid_o), .device_rdata_o(device_rdata_o),
      .pwm_req_o(pwm_req_o), .pwm_gnt_i(pwm_gnt_i), .pwm_addr_o(pwm_addr_o),
      .pwm_we_o(pwm_we_o), .pwm_be_o(pwm_be_o), .pwm_wdata_o(pwm_wdata_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i) begin
      #1;
      if (gnt_hold)      pwm_gnt_i = 1'b0;
      else if (gnt_rand) pwm_gnt_i = 1'($urandom_range(0, 1));
      else               pwm_gnt_i = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Beats are logged the half-cycle before the edge that completes them
   always @(negedge clk_i) begin
      if (rst_ni && prev_stall) begin
         chk("stall_req", 32'(pwm_req_o), 1);
         chk("stall_addr", pwm_addr_o, prev_a);
         chk("stall_data", pwm_wdata_o, prev_d);
      end
      if (rst_ni && pwm_req_o && pwm_gnt_i) begin
         q_addr.push_back(pwm_addr_o);
         q_data.push_back(pwm_wdata_o);
         q_cyc.push_back(cyc);
      end
      prev_stall = rst_ni && pwm_req_o && !pwm_gnt_i;
      prev_a     = pwm_addr_o;
      prev_d     = pwm_wdata_o;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic bus_wr(input logic [9:0] a, input logic [31:0] d);
      device_req_i = 1'b1; device_we_i = 1'b1; device_addr_i = {22'h0, a}; device_wdata_i = d;
      step();
      device_req_i = 1'b0; device_we_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [9:0] a, output logic [31:0] d);
      device_req_i = 1'b1; device_we_i = 1'b0; device_addr_i = {22'h0, a};
      step();
      device_req_i = 1'b0;
      d = device_rdata_o;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0; gnt_hold = 0; gnt_rand = 0;
      device_req_i = 1'b0; device_we_i = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();
      q_addr.delete(); q_data.delete(); q_cyc.delete();
   endtask

   task automatic wait_idle(input int budget);
      logic [31:0] s;
      int n = 0;
      do begin
         bus_rd(A_STAT, s);
         n++;
      end while (s[17] && n < budget);
      chk("wait_idle_busy", 32'(s[17]), 0);
   endtask

   function automatic void ramp(inout int lvl, inout bit dn, input int mx);
      if (lvl > mx) begin
         lvl = mx; dn = 1;
      end else if (!dn) begin
         if (lvl == mx) begin dn = 1; lvl = (mx == 0) ? 0 : lvl - 1; end
         else lvl = lvl + 1;
      end else begin
         if (lvl == 0) begin dn = 0; lvl = (mx == 0) ? 0 : 1; end
         else lvl = lvl - 1;
      end
   endfunction

   // INIT prefix then whole UPDATE sequences, each one ramp step past the previous
   task automatic check_seq(input logic [11:0] mask, input int mx, input int p,
                            input bit chk_gap, input int min_chunks);
      int ch[$];
      int lvl = 0, k, nch, b;
      bit dn = 0;
      for (int i = 0; i < 12; i++) if (mask[i]) ch.push_back(i);
      k = ch.size();
      chk("init_len", 32'(q_addr.size() >= k), 1);
      for (int j = 0; j < k && j < q_addr.size(); j++) begin
         chk("init_addr", q_addr[j], 32'(ch[j] * 8 + 4));
         chk("init_data", q_data[j], 32'(mx));
      end
      nch = (k == 0 || q_addr.size() < k) ? 0 : (q_addr.size() - k) / k;
      chk("update_count", 32'(nch >= min_chunks), 1);
      for (int u = 0; u < nch; u++) begin
         ramp(lvl, dn, mx);
         b = k + u * k;
         for (int j = 0; j < k; j++) begin
            chk("upd_addr", q_addr[b + j], 32'(ch[j] * 8));
            chk("upd_data", q_data[b + j], 32'(lvl));
         end
         if (chk_gap && u > 0) chk("tick_gap", 32'(q_cyc[b] - q_cyc[b - k]), 32'(p + 1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] s, r;
      logic [11:0] mask;
      int mx, p, k, n, n0;
      logic [31:0] a0, d0;

      // Reset state and register access
      do_reset();
      chk("rst_req", 32'(pwm_req_o), 0);
      chk("rst_rvalid", 32'(device_rvalid_o), 0);
      chk("rst_we", 32'(pwm_we_o), 1);
      chk("rst_be", 32'(pwm_be_o), 32'hF);
      chk("rst_addr", pwm_addr_o, 0);
      chk("rst_wdata", pwm_wdata_o, 0);
      bus_rd(A_STAT, s);
      chk("rd_rvalid", 32'(device_rvalid_o), 1);
      chk("rst_status", s, 0);
      bus_rd(A_MAX, s);
      chk("rst_max", s, 0);
      r = $urandom; bus_wr(A_PRESC, r); bus_rd(A_PRESC, s); chk("rb_prescale", s, r & 32'hFFFF);
      r = $urandom; bus_wr(A_MAX, r);   bus_rd(A_MAX, s);   chk("rb_max", s, r & 32'hFF);
      r = $urandom; bus_wr(A_MASK, r);  bus_rd(A_MASK, s);  chk("rb_mask", s, r & 32'hFFF);
      bus_wr(A_STAT, 32'hFFFF_FFFF);
      bus_rd(A_STAT, s);  chk("status_ro", s, 0);
      bus_rd(10'h014, s); chk("unmapped", s, 0);
      repeat (4) step();
      chk("no_beats_disabled", 32'(q_addr.size()), 0);

      // INIT sequence: MAX written to every enabled channel's counter-max register
      for (int it = 0; it < 3; it++) begin
         do_reset();
         mask = (it == 0) ? 12'h005 : 12'($urandom);
         mx   = (it == 0) ? 10 : $urandom_range(0, 255);
         gnt_rand = (it != 0);
         bus_wr(A_PRESC, 32'hFFFF);
         bus_wr(A_MAX, 32'(mx));
         bus_wr(A_MASK, 32'(mask));
         bus_wr(A_CTRL, 1);
         wait_idle(200);
         chk("init_beats", 32'(q_addr.size()), 32'($countones(mask)));
         check_seq(mask, mx, 0, 0, 0);
      end

      // Ramp over several ticks with a clean prescaler cadence
      for (int it = 0; it < 3; it++) begin
         do_reset();
         mask = (it == 0) ? 12'h001 : 12'($urandom_range(1, 12'hFFF));
         k    = $countones(mask);
         p    = (it == 0) ? 3 : k + 2 + $urandom_range(0, 2);
         mx   = (it == 0) ? 2 : $urandom_range(1, 5);
         bus_wr(A_PRESC, 32'(p));
         bus_wr(A_MAX, 32'(mx));
         bus_wr(A_MASK, 32'(mask));
         bus_wr(A_CTRL, 1);
         repeat ((p + 1) * 6 + 20) step();
         bus_rd(A_STAT, s);
         chk("ramp_no_overrun", 32'(s[18]), 0);
         bus_wr(A_CTRL, 0);
         wait_idle(40);
         check_seq(mask, mx, p, 1, 6);
      end

      // Grant withheld during an UPDATE beat
      do_reset();
      bus_wr(A_PRESC, 20); bus_wr(A_MAX, 3); bus_wr(A_MASK, 3); bus_wr(A_CTRL, 1);
      wait_idle(50);
      gnt_hold = 1;
      n = 0;
      while (!pwm_req_o && n < 40) begin step(); n++; end
      chk("stall_req_seen", 32'(pwm_req_o), 1);
      a0 = pwm_addr_o; d0 = pwm_wdata_o; n0 = q_addr.size();
      chk("stall_first_addr", a0, 0);
      chk("stall_first_data", d0, 1);
      repeat (5) step();
      chk("stall_addr_held", pwm_addr_o, a0);
      chk("stall_no_beat", 32'(q_addr.size()), 32'(n0));
      gnt_hold = 0;
      wait_idle(50);
      chk("stall_total", 32'(q_addr.size()), 32'(n0 + 2));
      check_seq(12'h003, 3, 0, 0, 1);

      // EN cleared while a beat is stalled
      do_reset();
      bus_wr(A_PRESC, 30); bus_wr(A_MAX, 9); bus_wr(A_MASK, 32'hFFF); bus_wr(A_CTRL, 1);
      wait_idle(60);
      gnt_hold = 1;
      n = 0;
      while (!pwm_req_o && n < 60) begin step(); n++; end
      chk("abort_req_seen", 32'(pwm_req_o), 1);
      bus_wr(A_CTRL, 0);
      repeat (2) step();
      n0 = q_addr.size();
      chk("abort_init_count", 32'(n0), 12);
      gnt_hold = 0;
      n = 0;
      while (q_addr.size() == n0 && n < 10) begin step(); n++; end
      chk("abort_one_beat", 32'(q_addr.size()), 32'(n0 + 1));
      chk("abort_req_low", 32'(pwm_req_o), 0);
      bus_rd(A_STAT, s);
      chk("abort_busy", 32'(s[17]), 0);
      chk("abort_level_kept", s & 32'h1_00FF, 32'h0000_0001);
      repeat (40) step();
      chk("abort_no_more", 32'(q_addr.size()), 32'(n0 + 1));

      // MAX lowered below the current level
      do_reset();
      bus_wr(A_PRESC, 12); bus_wr(A_MAX, 20); bus_wr(A_MASK, 1); bus_wr(A_CTRL, 1);
      n = 0;
      while (!(q_data.size() > 1 && q_data[$] == 8) && n < 400) begin step(); n++; end
      chk("reach_level8", 32'(q_data.size() > 1 && q_data[$] == 8), 1);
      bus_wr(A_MAX, 5);
      n0 = q_addr.size(); n = 0;
      while (q_addr.size() == n0 && n < 40) begin step(); n++; end
      chk("clamp_beat", 32'(q_addr.size()), 32'(n0 + 1));
      if (q_addr.size() > n0) chk("clamp_data", q_data[n0], 5);
      bus_rd(A_STAT, s);
      chk("clamp_status", s & 32'h1_00FF, 32'h1_0005);
      n = 0;
      while (q_addr.size() == n0 + 1 && n < 40) begin step(); n++; end
      if (q_addr.size() > n0 + 1) chk("after_clamp_data", q_data[n0 + 1], 4);
      else chk("after_clamp_beat", 32'(q_addr.size()), 32'(n0 + 2));

      // Continuous ticks while busy: pending then overrun
      do_reset();
      bus_wr(A_PRESC, 0); bus_wr(A_MAX, 50); bus_wr(A_MASK, 32'hFFF); bus_wr(A_CTRL, 1);
      repeat (80) step();
      bus_rd(A_STAT, s);
      chk("overrun_set", 32'(s[18]), 1);
      bus_wr(A_CTRL, 0);
      wait_idle(40);
      bus_rd(A_STAT, s);
      chk("overrun_sticky", 32'(s[18]), 1);
      bus_wr(A_STAT, 32'h0004_0000);
      bus_rd(A_STAT, s);
      chk("overrun_cleared", 32'(s[18]), 0);
      check_seq(12'hFFF, 50, 0, 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Autonomous bus master that generates "breathing" fades on the PWM channel array. Sits directly upstream of the PWM wrapper and drives that wrapper's device-bus write port. The CPU configures it through its own device-bus slave port. It ramps a shared duty level up and down and rewrites each enabled channel's pulse-width register on every prescaler tick.

Parameters:
NumChannels, 12, number of downstream PWM channels; at most 64 so the channel map fits in 10 address bits.
CtrSize, 8, PWM counter/pulse-width width in bits.
BusWidth, 32, bus data/address width.
PrescaleWidth, 16, tick prescaler width.

Ports:
clk_i  in  1  clock (already decided).
rst_ni  in  1  reset, asynchronous, active-low (already decided).
device_req_i  in  1  slave request.
device_addr_i  in  BusWidth  slave address; bits [9:0] decoded.
device_we_i  in  1  slave write enable.
device_be_i  in  4  byte enables; ignored, full-word access only.
device_wdata_i  in  BusWidth  slave write data.
device_rvalid_o  out  1  response valid, 1 cycle after req.
device_rdata_o  out  BusWidth  read data, valid with rvalid.
pwm_req_o  out  1  master write request to PWM wrapper.
pwm_gnt_i  in  1  master grant; beat completes on req & gnt.
pwm_addr_o  out  BusWidth  master address.
pwm_we_o  out  1  always 1.
pwm_be_o  out  4  always 4'hF.
pwm_wdata_o  out  BusWidth  zero-extended CtrSize value.

Behaviour:
- Register map (offset; field; reset):
  - 0x00 CTRL: bit0 EN; reset 0.
  - 0x04 PRESCALE: [PrescaleWidth-1:0]; reset 0.
  - 0x08 MAX: [CtrSize-1:0]; reset 0.
  - 0x0C CH_MASK: [NumChannels-1:0]; reset 0.
  - 0x10 STATUS (RO): [CtrSize-1:0] level, bit16 dir (1=down), bit17 busy, bit18 overrun (sticky; write 1 to 0x10 clears).
- Slave port:
  - Writes take effect on the req cycle.
  - device_rvalid_o <= device_req_i.
  - rdata registered with rvalid; unmapped offsets read 0.
- Reset values: all outputs 0 except pwm_we_o=1, pwm_be_o=4'hF. Internal state: level 0, dir up, FSM IDLE.
- Downstream map:
  - Channel i pulse width at 10-bit address i*8.
  - Channel i counter max at i*8+4.
- Prescaler:
  - While EN=1, counts down from PRESCALE to 0; tick on the cycle it reads 0, then reloads.
  - PRESCALE=0 ticks every cycle.
  - EN=0 holds the counter at PRESCALE.
- Level ramp, applied on tick when FSM accepts it:
  - dir up: level==MAX -> dir down, level-1 (level stays 0 if MAX=0); else level+1.
  - dir down: level==0 -> dir up, level+1 (stays 0 if MAX=0); else level-1.
  - If level>MAX (MAX lowered), set level=MAX and dir down.
- FSM: IDLE, INIT, UPDATE.
  - IDLE -> INIT on EN rising edge (0->1 write).
  - INIT: for each channel with its CH_MASK bit set, in ascending index order, write MAX to i*8+4. Then go to IDLE.
  - IDLE -> UPDATE on tick or pending tick. Write current level to i*8 for each channel with its mask bit set, ascending, then go to IDLE.
  - Masked channels are skipped with zero cycles spent.
  - Empty mask: INIT/UPDATE return to IDLE next cycle with no beats.
- Beat handshake:
  - addr/wdata stable while req=1 and gnt=0.
  - Next beat may present in the cycle after a grant.
  - Back-to-back beats allowed.
  - busy = FSM != IDLE.
- Tick while busy:
  - Set a one-deep pending flag.
  - A second tick while pending is set sets overrun; the tick is dropped.
- EN cleared mid-sequence:
  - A beat in flight (req high) completes on gnt.
  - Then go to IDLE and clear pending.
  - level/dir are kept.
- CTRL write and tick in the same cycle: the written EN value wins; a tick with EN written 0 is ignored.
- MAX/CH_MASK writes during UPDATE take effect for channels not yet issued.

Decomposition:
- Package pwm_fade_pkg: register offset localparams; FSM state enum (IDLE, INIT, UPDATE); downstream stride localparams (PW_OFFSET=0, CTR_OFFSET=4, CH_STRIDE=8).
- One sub-module: pwm_fade_prescaler (counter + tick + reload).
- Register file, ramp and FSM stay in the top module.

Test Plan:
- Reset -> pwm_req_o=0, rvalid=0, STATUS reads 0; CH_MASK=0x5, MAX=10, EN=1 -> two beats: addr 0x004 data 10, then addr 0x014 data 10; FSM back to IDLE.
- PRESCALE=3, MAX=2, mask=0x1, gnt tied 1 -> ticks every 4 cycles; writes to addr 0x000 carry levels 1,2,1,0,1 across ticks.
- gnt held 0 for 5 cycles during UPDATE -> req/addr/wdata stable throughout; beat completes on the first gnt.
- PRESCALE=0, mask=0xFFF, gnt=1 -> ticks pending while busy; second pending tick sets overrun; writing 1 to 0x10 clears overrun.
- EN written 0 during a gnt-stalled beat -> beat finishes on gnt, no further beats, busy=0 next cycle.
- Level=8 ramping up, MAX written 5 -> next tick writes 5 and STATUS dir=1.
